// File: rtl/life_scheduler.sv
// Sweep sequencer for the Game-of-Life datapath: converts keyboard control
// levels into evolve/clear/load row sweeps and paces generations.
module life_scheduler #(
  parameter int P_PARAM_N    = 64,
  parameter int P_PARAM_M    = 64,
  parameter int P_BASE_TICKS = 1024
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        manual,
  input  logic [15:0] file_id,
  input  logic [3:0]  evo_left_shift,
  output logic        row_req,
  output logic [15:0] row_idx,
  output logic [1:0]  row_op,
  output logic [15:0] load_id,
  input  logic        row_ack,
  output logic        running,
  output logic        busy,
  output logic        gen_tick,
  output logic [31:0] gen_count
);

  if (P_PARAM_N < 1 || P_PARAM_M < 1 || P_PARAM_M > 65535 || P_BASE_TICKS < 2) begin : gParamCheck
    $error("life_scheduler: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, WAIT, EVOLVE, CLEAR, LOAD} state_t;

  localparam logic [1:0]  OP_EVOLVE = 2'b00;
  localparam logic [1:0]  OP_CLEAR  = 2'b01;
  localparam logic [1:0]  OP_LOAD   = 2'b10;
  localparam logic [15:0] LAST_ROW  = 16'(P_PARAM_M - 1);
  localparam logic [31:0] BASE      = 32'(P_BASE_TICKS);

  state_t      state_q;
  logic [31:0] timer_q;
  logic        running_q;
  logic        rowReq_q;
  logic [15:0] rowIdx_q;
  logic [1:0]  rowOp_q;
  logic [15:0] loadId_q;
  logic [15:0] lastId_q;
  logic        genTick_q;
  logic [31:0] genCount_q;
  logic        startPrev_q, pausePrev_q, clearPrev_q;
  logic        startPend_q, pausePend_q, clearPend_q, loadPend_q;

  logic        startEdge, pauseEdge, clearEdge;
  logic [2:0]  shiftClamp;
  logic [31:0] waitLimit;
  logic        sweepState, sweepDone, decide, xfer, lastXfer, fileChg;

  assign startEdge  = start & ~startPrev_q;
  assign pauseEdge  = pause & ~pausePrev_q;
  assign clearEdge  = clear & ~clearPrev_q;
  assign shiftClamp = (evo_left_shift > 4'd5) ? 3'd5 : evo_left_shift[2:0];
  assign waitLimit  = (BASE << shiftClamp) - 32'd1;
  assign sweepState = (state_q == EVOLVE) || (state_q == CLEAR) || (state_q == LOAD);
  // A sweep state with the request dropped is the cycle after the last row.
  assign sweepDone  = sweepState & ~rowReq_q;
  assign decide     = (state_q == IDLE) || (state_q == WAIT) || sweepDone;
  assign xfer       = rowReq_q & row_ack;
  assign lastXfer   = xfer && (rowIdx_q == LAST_ROW);
  assign fileChg    = (file_id != lastId_q) && !running_q && !manual;

  // Pending flags are only cleared when already set, so a fresh edge in the
  // same cycle is not lost; the load flag is the exception because the file
  // compare still sees the old id on the cycle the load starts.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      running_q   <= 1'b0;
      rowReq_q    <= 1'b0;
      rowIdx_q    <= '0;
      rowOp_q     <= OP_EVOLVE;
      loadId_q    <= '0;
      lastId_q    <= '0;
      genTick_q   <= 1'b0;
      genCount_q  <= '0;
      startPrev_q <= 1'b0;
      pausePrev_q <= 1'b0;
      clearPrev_q <= 1'b0;
      startPend_q <= 1'b0;
      pausePend_q <= 1'b0;
      clearPend_q <= 1'b0;
      loadPend_q  <= 1'b1;
    end else begin
      startPrev_q <= start;
      pausePrev_q <= pause;
      clearPrev_q <= clear;
      genTick_q   <= 1'b0;
      if (startEdge) startPend_q <= 1'b1;
      if (pauseEdge) pausePend_q <= 1'b1;
      if (clearEdge) clearPend_q <= 1'b1;
      if (fileChg)   loadPend_q  <= 1'b1;

      if (xfer) begin
        if (lastXfer) begin
          rowReq_q <= 1'b0;
          if (state_q == EVOLVE) begin
            genCount_q <= genCount_q + 32'd1;
            genTick_q  <= 1'b1;
          end else begin
            genCount_q <= '0;
          end
        end else begin
          rowIdx_q <= rowIdx_q + 16'd1;
        end
      end

      if (decide) begin
        if (clearPend_q) begin
          clearPend_q <= 1'b0;
          running_q   <= 1'b0;
          state_q     <= CLEAR;
          rowReq_q    <= 1'b1;
          rowIdx_q    <= '0;
          rowOp_q     <= OP_CLEAR;
        end else if (loadPend_q) begin
          loadPend_q <= 1'b0;
          loadId_q   <= file_id;
          lastId_q   <= file_id;
          state_q    <= LOAD;
          rowReq_q   <= 1'b1;
          rowIdx_q   <= '0;
          rowOp_q    <= OP_LOAD;
        end else if (pausePend_q) begin
          pausePend_q <= 1'b0;
          running_q   <= 1'b0;
          state_q     <= IDLE;
        end else if (startPend_q && !manual && !running_q) begin
          startPend_q <= 1'b0;
          running_q   <= 1'b1;
          state_q     <= WAIT;
          timer_q     <= '0;
        end else begin
          if (startPend_q) startPend_q <= 1'b0;
          if (state_q == WAIT) begin
            if (timer_q >= waitLimit) begin
              state_q  <= EVOLVE;
              rowReq_q <= 1'b1;
              rowIdx_q <= '0;
              rowOp_q  <= OP_EVOLVE;
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end else if (sweepDone) begin
            if (running_q) begin
              state_q <= WAIT;
              timer_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      end
    end
  end

  assign row_req   = rowReq_q;
  assign row_idx   = rowIdx_q;
  assign row_op    = rowOp_q;
  assign load_id   = loadId_q;
  assign running   = running_q;
  assign busy      = sweepState;
  assign gen_tick  = genTick_q;
  assign gen_count = genCount_q;

endmodule

// File: tb/tb_life_scheduler.sv
// Scoreboard bench for life_scheduler: expected row transfers and generation
// counts are queued by the stimulus and consumed by an independent monitor.
module tb_life_scheduler;
  localparam int M    = 4;
  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0, manual = 1'b0;
  logic [15:0] file_id = 16'd3;
  logic [3:0]  evo_left_shift = 4'd0;
  logic        row_ack = 1'b1;
  logic        row_req, running, busy, gen_tick;
  logic [15:0] row_idx, load_id;
  logic [1:0]  row_op;
  logic [31:0] gen_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] idx;
    logic [1:0]  op;
    logic [15:0] id;
  } rowExp_t;

  rowExp_t     expRows[$];
  logic [31:0] expGen[$];
  int          modelGen = 0;
  logic [15:0] modelId  = 16'd0;

  logic ackLevel   = 1'b1;
  logic randomMode = 1'b0;

  life_scheduler #(.P_PARAM_N(8), .P_PARAM_M(M), .P_BASE_TICKS(BASE)) dut (
    .clk_in(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .manual(manual), .file_id(file_id), .evo_left_shift(evo_left_shift),
    .row_req(row_req), .row_idx(row_idx), .row_op(row_op), .load_id(load_id),
    .row_ack(row_ack), .running(running), .busy(busy), .gen_tick(gen_tick),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // Acknowledge driver: either a fixed level or random back-pressure.
  always @(posedge clk) begin
    #2;
    row_ack = randomMode ? ($urandom_range(3, 0) != 0) : ackLevel;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int periodOf(input int shift);
    int s;
    s = (shift > 5) ? 5 : shift;
    return BASE * (1 << s);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic m,
                               input logic [15:0] f, input logic [3:0] e);
    start = s; pause = p; clear = c; manual = m; file_id = f; evo_left_shift = e;
  endtask

  // Reference model: a sweep is M rows in order; evolve bumps the count, clear/load zero it.
  task automatic pushSweep(input logic [1:0] op, input logic [15:0] id);
    rowExp_t e;
    for (int i = 0; i < M; i++) begin
      e.idx = 16'(i); e.op = op; e.id = id;
      expRows.push_back(e);
    end
    if (op == 2'b00) begin
      modelGen++;
      expGen.push_back(32'(modelGen));
    end else begin
      modelGen = 0;
    end
  endtask

  task automatic waitTick(input string name, input int budget, output time t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!gen_tick && n < budget);
    if (!gen_tick) checkOutput(name, {31'd0, gen_tick}, 32'd1);
    t = $time;
  endtask

  task automatic waitBusy(input string name, input logic level, input int budget);
    int n = 0;
    while (busy !== level && n < budget) begin @(negedge clk); n++; end
    if (busy !== level) checkOutput(name, {31'd0, busy}, {31'd0, level});
  endtask

  task automatic waitSweepDone(input string name);
    waitBusy({name, "_start"}, 1'b1, 200);
    waitBusy({name, "_end"}, 1'b0, 400);
  endtask

  // Monitor: consumes expectations on every accepted row and every gen_tick.
  logic    stallPrev = 1'b0;
  rowExp_t stallVal;
  always @(negedge clk) begin
    if (reset) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("hold_req", {31'd0, row_req}, 32'd1);
        checkOutput("hold_idx", {16'd0, row_idx}, {16'd0, stallVal.idx});
        checkOutput("hold_op",  {30'd0, row_op},  {30'd0, stallVal.op});
        checkOutput("hold_id",  {16'd0, load_id}, {16'd0, stallVal.id});
      end
      if (row_req && row_ack) begin
        if (expRows.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_row: got row %0d op %0d, expected none", row_idx, row_op);
        end else begin
          rowExp_t e;
          e = expRows.pop_front();
          checkOutput("row_idx", {16'd0, row_idx}, {16'd0, e.idx});
          checkOutput("row_op",  {30'd0, row_op},  {30'd0, e.op});
          checkOutput("load_id", {16'd0, load_id}, {16'd0, e.id});
        end
      end
      if (gen_tick) begin
        if (expGen.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_tick: got gen_count %0d, expected no tick", gen_count);
        end else begin
          checkOutput("gen_count_tick", gen_count, expGen.pop_front());
        end
      end
      stallPrev    = row_req && !row_ack;
      stallVal.idx = row_idx;
      stallVal.op  = row_op;
      stallVal.id  = load_id;
    end
  end

  initial begin
    time t1, t2, t3;
    int  n;
    int  sh;
    logic [15:0] newId;

    $display("[TB] reset with file_id=3");
    repeat (3) @(negedge clk);
    checkOutput("rst_row_req",   {31'd0, row_req}, 32'd0);
    checkOutput("rst_row_idx",   {16'd0, row_idx}, 32'd0);
    checkOutput("rst_row_op",    {30'd0, row_op},  32'd0);
    checkOutput("rst_load_id",   {16'd0, load_id}, 32'd0);
    checkOutput("rst_running",   {31'd0, running}, 32'd0);
    checkOutput("rst_busy",      {31'd0, busy},    32'd0);
    checkOutput("rst_gen_tick",  {31'd0, gen_tick},32'd0);
    checkOutput("rst_gen_count", gen_count,        32'd0);
    pushSweep(2'b10, 16'd3);
    modelId = 16'd3;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_load_lat", {31'd0, row_req}, 32'd1);
    waitBusy("reset_load_end", 1'b0, 100);
    checkOutput("after_load_gen", gen_count, 32'd0);
    checkOutput("after_load_run", {31'd0, running}, 32'd0);
    checkOutput("after_load_id",  {16'd0, load_id}, {16'd0, modelId});

    $display("[TB] free-running generations at shift 0");
    for (int g = 0; g < 3; g++) pushSweep(2'b00, modelId);
    applyStimulus(1, 0, 0, 0, modelId, 4'd0);
    waitTick("tick1_timeout", 100, t1);
    checkOutput("running_on", {31'd0, running}, 32'd1);
    waitTick("tick2_timeout", 100, t2);
    waitTick("tick3_timeout", 100, t3);
    checkOutput("interval_1", 32'((t2 - t1) / 10), 32'(periodOf(0) + M + 1));
    checkOutput("interval_2", 32'((t3 - t2) / 10), 32'(periodOf(0) + M + 1));
    applyStimulus(0, 1, 0, 0, modelId, 4'd0);
    repeat (5) @(negedge clk);
    checkOutput("paused_run", {31'd0, running}, 32'd0);
    applyStimulus(0, 0, 0, 0, modelId, 4'd0);
    repeat (30) @(negedge clk);
    checkOutput("paused_busy", {31'd0, busy}, 32'd0);

    $display("[TB] stall on row 2 then random back-pressure");
    for (int g = 0; g < 2; g++) pushSweep(2'b00, modelId);
    applyStimulus(1, 0, 0, 0, modelId, 4'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(row_req && row_idx == 16'd1 && row_ack) && n < 200);
    checkOutput("stall_found", {31'd0, row_req}, 32'd1);
    ackLevel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_req", {31'd0, row_req}, 32'd1);
      checkOutput("stall_idx", {16'd0, row_idx}, 32'd2);
    end
    randomMode = 1'b1;
    ackLevel   = 1'b1;
    waitTick("tick4_timeout", 300, t1);
    waitTick("tick5_timeout", 300, t2);
    applyStimulus(0, 1, 0, 0, modelId, 4'd0);
    repeat (5) @(negedge clk);
    randomMode = 1'b0;
    applyStimulus(0, 0, 0, 0, modelId, 4'd0);
    repeat (10) @(negedge clk);

    $display("[TB] pause and clear during an evolve sweep");
    pushSweep(2'b00, modelId);
    pushSweep(2'b01, modelId);
    applyStimulus(1, 0, 0, 0, modelId, 4'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(row_req && row_idx == 16'd1) && n < 200);
    checkOutput("mid_evolve_op", {30'd0, row_op}, 32'd0);
    applyStimulus(1, 1, 1, 0, modelId, 4'd0);
    waitTick("tick6_timeout", 50, t1);
    waitBusy("clear_end", 1'b0, 100);
    checkOutput("clear_gen", gen_count, 32'd0);
    checkOutput("clear_run", {31'd0, running}, 32'd0);
    checkOutput("clear_op",  {30'd0, row_op}, 32'd1);
    applyStimulus(0, 0, 0, 0, modelId, 4'd0);
    repeat (40) @(negedge clk);
    checkOutput("after_clear_idle", {31'd0, busy}, 32'd0);

    $display("[TB] manual mode and file changes");
    applyStimulus(1, 0, 0, 1, 16'd5, 4'd0);
    repeat (40) @(negedge clk);
    checkOutput("manual_run",  {31'd0, running}, 32'd0);
    checkOutput("manual_busy", {31'd0, busy}, 32'd0);
    pushSweep(2'b10, 16'd5);
    modelId = 16'd5;
    applyStimulus(0, 0, 0, 0, 16'd5, 4'd0);
    waitSweepDone("load5");
    checkOutput("load5_id", {16'd0, load_id}, 32'd5);
    pushSweep(2'b10, 16'd7);
    modelId = 16'd7;
    applyStimulus(0, 0, 0, 0, 16'd7, 4'd0);
    @(negedge clk);
    checkOutput("load_lat_early", {31'd0, row_req}, 32'd0);
    @(negedge clk);
    checkOutput("load_lat", {31'd0, row_req}, 32'd1);
    waitBusy("load7_end", 1'b0, 100);
    checkOutput("load7_id", {16'd0, load_id}, 32'd7);

    $display("[TB] clamped speed exponent and live shrink");
    sh = $urandom_range(15, 6);
    for (int g = 0; g < 3; g++) pushSweep(2'b00, modelId);
    applyStimulus(1, 0, 0, 0, modelId, 4'(sh));
    waitTick("slow_tick1_timeout", 2000, t1);
    waitTick("slow_tick2_timeout", 2000, t2);
    checkOutput("slow_interval", 32'((t2 - t1) / 10), 32'(periodOf(sh) + M + 1));
    repeat (101) @(negedge clk);
    checkOutput("shrink_before", {31'd0, row_req}, 32'd0);
    applyStimulus(1, 0, 0, 0, modelId, 4'd0);
    @(negedge clk);
    checkOutput("shrink_evolve", {31'd0, row_req}, 32'd1);
    waitTick("slow_tick3_timeout", 100, t3);
    applyStimulus(0, 1, 0, 0, modelId, 4'd0);
    repeat (5) @(negedge clk);
    applyStimulus(0, 0, 0, 0, modelId, 4'd0);
    checkOutput("slow_paused", {31'd0, running}, 32'd0);

    $display("[TB] random file loads under back-pressure");
    randomMode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      do newId = 16'($urandom_range(65535, 1)); while (newId == modelId);
      pushSweep(2'b10, newId);
      modelId = newId;
      applyStimulus(0, 0, 0, 0, newId, 4'd0);
      waitSweepDone("rand_load");
      checkOutput("rand_load_id",  {16'd0, load_id}, {16'd0, newId});
      checkOutput("rand_load_gen", gen_count, 32'd0);
    end
    randomMode = 1'b0;

    repeat (20) @(negedge clk);
    checkOutput("rows_drained", 32'(expRows.size()), 32'd0);
    checkOutput("gens_drained", 32'(expGen.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
